// File: rtl/mem_port_arbiter_if.sv
// Block-port bundle between the two cache controllers, the arbiter and main memory.
// The master side is the arbiter: it answers both caches and drives the memory command.
// The slave side is the surrounding environment (caches plus memory model).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);

  // Instruction-cache side (read-only refills)
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  // Data-cache side (refills and write-backs)
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  // Main-memory side
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_busywait;

  modport master (
    input  i_read, i_address,
    output i_readdata, i_busywait,
    input  d_read, d_write, d_address, d_writedata,
    output d_readdata, d_busywait,
    output m_read, m_write, m_address, m_writedata,
    input  m_readdata, m_busywait
  );

  modport slave (
    output i_read, i_address,
    input  i_readdata, i_busywait,
    output d_read, d_write, d_address, d_writedata,
    input  d_readdata, d_busywait,
    input  m_read, m_write, m_address, m_writedata,
    output m_readdata, m_busywait
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single 128-bit main-memory block port between the I-cache (refills)
// and the D-cache (refills and write-backs). One transaction is in flight at a time.
// The loser of a contention simply stays in busywait until its own grant completes.
module mem_port_arbiter #(
  parameter int ADDR_W           = 28,
  parameter int DATA_W           = 128,
  parameter int FIXED_D_PRIORITY = 0
) (
  input logic                clock,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    GNT_I,
    GNT_D,
    DONE_I,
    DONE_D
  } state_t;

  typedef enum logic {
    RR_I,
    RR_D
  } rr_t;

  state_t            state_q, state_d;
  rr_t               rr_last_q, rr_last_d;
  logic              started_q, started_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [DATA_W-1:0] m_writedata_q, m_writedata_d;
  logic [DATA_W-1:0] i_readdata_q, i_readdata_d;
  logic [DATA_W-1:0] d_readdata_q, d_readdata_d;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  // Decide who would win if arbitration happened this cycle: D wins when alone,
  // when fixed priority is selected, or when I won the previous grant.
  always_comb begin
    i_req   = bus.i_read;
    d_req   = bus.d_read | bus.d_write;
    grant_d = d_req && (!i_req || (FIXED_D_PRIORITY != 0) || (rr_last_q == RR_I));
    grant_i = i_req && !grant_d;
  end

  // Next-state and next-output computation for the grant/complete/release sequence.
  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    started_d     = started_q;
    m_read_d      = m_read_q;
    m_write_d     = m_write_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    i_readdata_d  = i_readdata_q;
    d_readdata_d  = d_readdata_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          m_read_d    = 1'b1;
          m_write_d   = 1'b0;
          m_address_d = bus.i_address;
          rr_last_d   = RR_I;
          started_d   = 1'b0;
          state_d     = GNT_I;
        end else if (grant_d) begin
          // A simultaneous read+write from the D-cache is a write-back.
          m_write_d     = bus.d_write;
          m_read_d      = !bus.d_write;
          m_address_d   = bus.d_address;
          m_writedata_d = bus.d_writedata;
          rr_last_d     = RR_D;
          started_d     = 1'b0;
          state_d       = GNT_D;
        end
      end

      GNT_I, GNT_D: begin
        // Memory busywait low before it has ever risen is not a completion.
        if (bus.m_busywait) begin
          started_d = 1'b1;
        end else if (started_q) begin
          if (m_read_q) begin
            if (state_q == GNT_I) begin
              i_readdata_d = bus.m_readdata;
            end else begin
              d_readdata_d = bus.m_readdata;
            end
          end
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = (state_q == GNT_I) ? DONE_I : DONE_D;
        end
      end

      DONE_I, DONE_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        m_read_d  = 1'b0;
        m_write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_last_q     <= RR_D;
      started_q     <= 1'b0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      i_readdata_q  <= '0;
      d_readdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      started_q     <= started_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      i_readdata_q  <= i_readdata_d;
      d_readdata_q  <= d_readdata_d;
    end
  end

  assign bus.m_read      = m_read_q;
  assign bus.m_write     = m_write_q;
  assign bus.m_address   = m_address_q;
  assign bus.m_writedata = m_writedata_q;
  assign bus.i_readdata  = i_readdata_q;
  assign bus.d_readdata  = d_readdata_q;

  // A requester is released only during its own one-cycle DONE state.
  assign bus.i_busywait = bus.i_read && (state_q != DONE_I);
  assign bus.d_busywait = (bus.d_read || bus.d_write) && (state_q != DONE_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 round-robin, instance 1 fixed D priority.
// A transaction-level model predicts every output each cycle; directed scenarios
// add hand-computed literal expectations on top.
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic clock;
  logic reset;

  // Requester and memory drive, one slot per instance
  logic          i_read_v  [2];
  logic [AW-1:0] i_addr_v  [2];
  logic          d_read_v  [2];
  logic          d_write_v [2];
  logic [AW-1:0] d_addr_v  [2];
  logic [DW-1:0] d_wdata_v [2];
  logic          m_busy_v  [2];
  logic [DW-1:0] m_rdata_v [2];

  // Observed DUT outputs
  wire           m_read_o  [2];
  wire           m_write_o [2];
  wire [AW-1:0]  m_addr_o  [2];
  wire [DW-1:0]  m_wdata_o [2];
  wire [DW-1:0]  i_rdata_o [2];
  wire [DW-1:0]  d_rdata_o [2];
  wire           i_busy_o  [2];
  wire           d_busy_o  [2];

  int total;
  int bad;

  // Memory model state
  int            mem_pre;
  int            mem_lat;
  logic [DW-1:0] mem [logic [AW:0]];
  int            mph  [2];
  int            mcnt [2];
  logic          mwr  [2];
  logic [AW-1:0] maddr[2];
  logic [DW-1:0] mwd  [2];

  // Arbiter model state: owner/done are 0 none, 1 I, 2 D
  int            own  [2];
  int            dn   [2];
  int            bcnt [2];
  int            last [2];
  logic          e_rd [2];
  logic          e_wr [2];
  logic [AW-1:0] e_addr[2];
  logic [DW-1:0] e_wd [2];
  logic [DW-1:0] e_ir [2];
  logic [DW-1:0] e_dr [2];

  // Grant log observed on the memory port
  typedef struct {
    int            gap;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } grant_t;
  grant_t glog0[$];
  grant_t glog1[$];
  int     gap_cnt [2];
  logic   prev_cmd[2];
  int     ilow;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .FIXED_D_PRIORITY(g)
    ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
    );

    assign bus.i_read      = i_read_v[g];
    assign bus.i_address   = i_addr_v[g];
    assign bus.d_read      = d_read_v[g];
    assign bus.d_write     = d_write_v[g];
    assign bus.d_address   = d_addr_v[g];
    assign bus.d_writedata = d_wdata_v[g];
    assign bus.m_busywait  = m_busy_v[g];
    assign bus.m_readdata  = m_rdata_v[g];

    assign m_read_o[g]  = bus.m_read;
    assign m_write_o[g] = bus.m_write;
    assign m_addr_o[g]  = bus.m_address;
    assign m_wdata_o[g] = bus.m_writedata;
    assign i_rdata_o[g] = bus.i_readdata;
    assign d_rdata_o[g] = bus.d_readdata;
    assign i_busy_o[g]  = bus.i_busywait;
    assign d_busy_o[g]  = bus.d_busywait;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_read(input int g, input logic [AW-1:0] a);
    logic [AW:0] key;
    key = {g[0], a};
    if (mem.exists(key)) return mem[key];
    return {4{a, 4'hA}};
  endfunction

  // Memory: after seeing a command, busy low for mem_pre cycles, high for mem_lat, then done
  task automatic mem_step(input int g);
    logic cmd;
    cmd = m_read_o[g] | m_write_o[g];
    if (reset) begin
      mph[g]      = 0;
      m_busy_v[g] = 1'b0;
      return;
    end
    if (mph[g] == 0 && cmd) begin
      mph[g]   = 1;
      mcnt[g]  = 0;
      mwr[g]   = m_write_o[g];
      maddr[g] = m_addr_o[g];
      mwd[g]   = m_wdata_o[g];
    end
    if (mph[g] == 1) begin
      if (mcnt[g] < mem_pre) m_busy_v[g] = 1'b0;
      else if (mcnt[g] < mem_pre + mem_lat) m_busy_v[g] = 1'b1;
      else begin
        m_busy_v[g] = 1'b0;
        if (mwr[g]) mem[{g[0], maddr[g]}] = mwd[g];
        else m_rdata_v[g] = mem_read(g, maddr[g]);
        mph[g] = 2;
      end
      mcnt[g]++;
    end else if (mph[g] == 2 && !cmd) begin
      mph[g] = 0;
    end
  endtask

  always begin
    @(posedge clock);
    #1;
    for (int g = 0; g < 2; g++) mem_step(g);
  end

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      own[g] = 0;  dn[g] = 0;  bcnt[g] = 0;  last[g] = 2;
      e_rd[g] = 1'b0;  e_wr[g] = 1'b0;  e_addr[g] = '0;
      e_wd[g] = '0;  e_ir[g] = '0;  e_dr[g] = '0;
    end
  endtask

  // One clock of the transaction model: release, arbitrate, or track the access
  task automatic model_step(input int g);
    int win;
    if (dn[g] != 0) begin
      dn[g] = 0;
    end else if (own[g] == 0) begin
      if (i_read_v[g] || d_read_v[g] || d_write_v[g]) begin
        if (!(d_read_v[g] || d_write_v[g])) win = 1;
        else if (!i_read_v[g]) win = 2;
        else if (g == 1) win = 2;
        else win = (last[g] == 1) ? 2 : 1;
        own[g]  = win;
        last[g] = win;
        bcnt[g] = 0;
        if (win == 1) begin
          e_rd[g] = 1'b1;  e_wr[g] = 1'b0;  e_addr[g] = i_addr_v[g];
        end else begin
          e_wr[g] = d_write_v[g];  e_rd[g] = !d_write_v[g];
          e_addr[g] = d_addr_v[g];  e_wd[g] = d_wdata_v[g];
        end
      end
    end else if (m_busy_v[g]) begin
      bcnt[g]++;
    end else if (bcnt[g] > 0) begin
      if (e_rd[g]) begin
        if (own[g] == 1) e_ir[g] = m_rdata_v[g];
        else e_dr[g] = m_rdata_v[g];
      end
      e_rd[g] = 1'b0;
      e_wr[g] = 1'b0;
      dn[g]   = own[g];
      own[g]  = 0;
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_reset();
    else for (int g = 0; g < 2; g++) model_step(g);
  end

  // Compare every output of both instances against the model on each falling edge
  always @(negedge clock) begin
    if (!reset) begin
      for (int g = 0; g < 2; g++) begin
        checkOutput($sformatf("u%0d_m_read", g), m_read_o[g], e_rd[g]);
        checkOutput($sformatf("u%0d_m_write", g), m_write_o[g], e_wr[g]);
        checkOutput($sformatf("u%0d_m_address", g), m_addr_o[g], e_addr[g]);
        checkOutput($sformatf("u%0d_m_writedata", g), m_wdata_o[g], e_wd[g]);
        checkOutput($sformatf("u%0d_i_readdata", g), i_rdata_o[g], e_ir[g]);
        checkOutput($sformatf("u%0d_d_readdata", g), d_rdata_o[g], e_dr[g]);
        checkOutput($sformatf("u%0d_i_busywait", g), i_busy_o[g], i_read_v[g] && (dn[g] != 1));
        checkOutput($sformatf("u%0d_d_busywait", g), d_busy_o[g],
                    (d_read_v[g] || d_write_v[g]) && (dn[g] != 2));
      end
    end
  end

  // Record each new memory command with the number of command-free cycles before it
  always @(negedge clock) begin
    for (int g = 0; g < 2; g++) begin
      logic   cmd;
      grant_t ent;
      cmd = m_read_o[g] | m_write_o[g];
      if (reset) begin
        gap_cnt[g]  = 0;
        prev_cmd[g] = 1'b0;
      end else begin
        if (cmd) begin
          if (!prev_cmd[g]) begin
            ent.gap = gap_cnt[g];  ent.wr = m_write_o[g];
            ent.addr = m_addr_o[g];  ent.wdata = m_wdata_o[g];
            if (g == 0) glog0.push_back(ent);
            else glog1.push_back(ent);
          end
          gap_cnt[g] = 0;
        end else begin
          gap_cnt[g]++;
        end
        prev_cmd[g] = cmd;
        if (g == 0 && i_read_v[0] && !i_busy_o[0]) ilow++;
      end
    end
  end

  // Set memory timing and pulse reset for two cycles
  task automatic applyStimulus(input int pre, input int lat);
    mem_pre = pre;
    mem_lat = lat;
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic req_i(input int g, input logic [AW-1:0] a, output bit ok, output int c);
    @(posedge clock);
    #2;
    i_read_v[g] = 1'b1;
    i_addr_v[g] = a;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < 200) begin
      @(negedge clock);
      c++;
      if (!i_busy_o[g]) ok = 1'b1;
    end
    @(posedge clock);
    #2 i_read_v[g] = 1'b0;
    checkOutput($sformatf("u%0d_i_req_done", g), ok, 1'b1);
  endtask

  task automatic req_d(input int g, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       output bit ok, output int c);
    @(posedge clock);
    #2;
    d_write_v[g] = wr;
    d_read_v[g]  = !wr;
    d_addr_v[g]  = a;
    d_wdata_v[g] = wd;
    ok = 1'b0;
    c  = 0;
    while (!ok && c < 200) begin
      @(negedge clock);
      c++;
      if (!d_busy_o[g]) ok = 1'b1;
    end
    @(posedge clock);
    #2;
    d_write_v[g] = 1'b0;
    d_read_v[g]  = 1'b0;
    checkOutput($sformatf("u%0d_d_req_done", g), ok, 1'b1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok1, ok2;
    int c1, c2;
    localparam logic [DW-1:0] W1 = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
    localparam logic [DW-1:0] W2 = 128'hDEADBEEF_CAFEF00D_01020304_05060708;

    total = 0;
    bad   = 0;
    ilow  = 0;
    reset = 1'b1;
    mem_pre = 0;
    mem_lat = 4;
    for (int g = 0; g < 2; g++) begin
      i_read_v[g] = 1'b0;  i_addr_v[g] = '0;
      d_read_v[g] = 1'b0;  d_write_v[g] = 1'b0;
      d_addr_v[g] = '0;  d_wdata_v[g] = '0;
      m_busy_v[g] = 1'b0;  m_rdata_v[g] = '0;
      mph[g] = 0;  mcnt[g] = 0;  gap_cnt[g] = 0;  prev_cmd[g] = 1'b0;
    end
    mem[{1'b0, 28'h0000012}] = 128'h0123456789ABCDEF0123456789ABCDEF;
    mem[{1'b0, 28'h0000020}] = 128'hFEDCBA9876543210FEDCBA9876543210;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;

    // Reset values
    @(negedge clock);
    checkOutput("rst_m_read", m_read_o[0], 1'b0);
    checkOutput("rst_m_write", m_write_o[0], 1'b0);
    checkOutput("rst_m_address", m_addr_o[0], 28'h0);
    checkOutput("rst_i_readdata", i_rdata_o[0], 128'h0);

    // Uncontended I refill, memory busy 4 cycles
    $display("[TB] uncontended I refill");
    applyStimulus(0, 4);
    glog0.delete();
    ilow = 0;
    req_i(0, 28'h0000012, ok1, c1);
    checkOutput("t1_latency", c1, 7);
    checkOutput("t1_i_readdata", i_rdata_o[0], 128'h0123456789ABCDEF0123456789ABCDEF);
    checkOutput("t1_release_cycles", ilow, 1);
    checkOutput("t1_grants", glog0.size(), 1);
    if (glog0.size() >= 1) begin
      checkOutput("t1_addr", glog0[0].addr, 28'h0000012);
      checkOutput("t1_is_read", glog0[0].wr, 1'b0);
    end

    // Round-robin contention from reset: I first, then D write after the idle gap
    $display("[TB] round-robin contention");
    applyStimulus(0, 3);
    glog0.delete();
    fork
      req_i(0, 28'h0000012, ok1, c1);
      req_d(0, 1'b1, 28'h0000040, W1, ok2, c2);
    join
    checkOutput("t2_grants", glog0.size(), 2);
    if (glog0.size() >= 2) begin
      checkOutput("t2_first_addr", glog0[0].addr, 28'h0000012);
      checkOutput("t2_first_is_read", glog0[0].wr, 1'b0);
      checkOutput("t2_second_addr", glog0[1].addr, 28'h0000040);
      checkOutput("t2_second_is_write", glog0[1].wr, 1'b1);
      checkOutput("t2_second_wdata", glog0[1].wdata, W1);
      checkOutput("t2_gap", glog0[1].gap, 2);
    end
    checkOutput("t2_d_readdata_kept", d_rdata_o[0], 128'h0);
    checkOutput("t2_mem_written", mem_read(0, 28'h0000040), W1);

    // I wins alone, so the next contention goes to D
    glog0.delete();
    req_i(0, 28'h0000013, ok1, c1);
    fork
      req_i(0, 28'h0000014, ok1, c1);
      req_d(0, 1'b0, 28'h0000041, '0, ok2, c2);
    join
    checkOutput("t2b_grants", glog0.size(), 3);
    if (glog0.size() >= 3) begin
      checkOutput("t2b_d_first", glog0[1].addr, 28'h0000041);
      checkOutput("t2b_i_second", glog0[2].addr, 28'h0000014);
    end
    checkOutput("t2b_d_readdata", d_rdata_o[0], 128'h0000041A0000041A0000041A0000041A);

    // Fixed D priority instance: D wins every contention
    $display("[TB] fixed D priority");
    glog1.delete();
    fork
      req_i(1, 28'h0000015, ok1, c1);
      req_d(1, 1'b0, 28'h0000042, '0, ok2, c2);
    join
    fork
      req_i(1, 28'h0000016, ok1, c1);
      req_d(1, 1'b1, 28'h0000043, W2, ok2, c2);
    join
    checkOutput("t3_grants", glog1.size(), 4);
    if (glog1.size() >= 4) begin
      checkOutput("t3_g0", glog1[0].addr, 28'h0000042);
      checkOutput("t3_g1", glog1[1].addr, 28'h0000015);
      checkOutput("t3_g2", glog1[2].addr, 28'h0000043);
      checkOutput("t3_g3", glog1[3].addr, 28'h0000016);
    end

    // Address change during an access must not reach the memory port
    $display("[TB] address change during grant");
    applyStimulus(0, 6);
    glog0.delete();
    fork
      req_i(0, 28'h0000012, ok1, c1);
      begin
        repeat (3) @(posedge clock);
        #2 i_addr_v[0] = 28'h0000034;
        repeat (3) begin
          @(negedge clock);
          checkOutput("t4_addr_hold", m_addr_o[0], 28'h0000012);
        end
      end
    join
    checkOutput("t4_grant_addr", (glog0.size() >= 1) ? glog0[0].addr : 28'h0, 28'h0000012);

    // Memory busywait rises late: no completion before the rise
    $display("[TB] late memory busywait");
    applyStimulus(2, 3);
    req_i(0, 28'h0000020, ok1, c1);
    checkOutput("t5_latency", c1, 8);
    checkOutput("t5_i_readdata", i_rdata_o[0], 128'hFEDCBA9876543210FEDCBA9876543210);

    // Asynchronous reset in the middle of a D write-back, then re-grant
    $display("[TB] reset mid D grant");
    applyStimulus(0, 5);
    glog0.delete();
    fork
      req_d(0, 1'b1, 28'h0000044, W2, ok2, c2);
      begin
        repeat (3) @(posedge clock);
        #2 checkOutput("t6_m_write_before", m_write_o[0], 1'b1);
        #1 reset = 1'b1;
        #1;
        checkOutput("t6_m_write_async", m_write_o[0], 1'b0);
        checkOutput("t6_m_read_async", m_read_o[0], 1'b0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
      end
    join
    checkOutput("t6_grants", glog0.size(), 2);
    if (glog0.size() >= 2) begin
      checkOutput("t6_regrant_addr", glog0[1].addr, 28'h0000044);
      checkOutput("t6_regrant_write", glog0[1].wr, 1'b1);
    end
    checkOutput("t6_mem_written", mem_read(0, 28'h0000044), W2);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
